// File: rtl/atmos_light_topk_if.sv
// Pixel-stream interface for atmos_light_topk: incoming frame stream plus the
// delayed sync signals and atmospheric-light estimate going out.
interface atmos_light_topk_if #(
  parameter int DW = 8
);
  // Streaming, no backpressure: a pixel transfers on any cycle where
  // pre_frame_vsync, pre_frame_href and pre_frame_clken are all high; the sink
  // is always ready. post_done / post_overrun are single-cycle strobes.
  logic              pre_frame_vsync;
  logic              pre_frame_href;
  logic              pre_frame_clken;
  logic [3*DW-1:0]   pre_img;
  logic [DW-1:0]     pre_key;

  logic              post_frame_vsync;
  logic              post_frame_href;
  logic              post_frame_clken;
  logic [DW-1:0]     post_a_r;
  logic [DW-1:0]     post_a_g;
  logic [DW-1:0]     post_a_b;
  logic              post_done;
  logic              post_overrun;

  modport master (
    output pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img, pre_key,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_a_r, post_a_g, post_a_b, post_done, post_overrun
  );

  modport slave (
    input  pre_frame_vsync, pre_frame_href, pre_frame_clken, pre_img, pre_key,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_a_r, post_a_g, post_a_b, post_done, post_overrun
  );
endinterface

// File: rtl/atmos_light_topk.sv
// Atmospheric light estimator: keeps the K brightest-key pixels of a frame and
// averages them after vsync falls. Optional ATMOS_LIGHT_SMOOTH_EN blends each new
// estimate with the previous one as (3*prev + new) >> 2.
module atmos_light_topk #(
  parameter int DW     = 8,
  parameter int K      = 8,
  parameter int A_INIT = 230
) (
  input  logic                clk,
  input  logic                rst_n,
  atmos_light_topk_if.slave   bus,
  output logic [1:0]          dbg_state
);
  localparam int LK = $clog2(K);
  localparam int IW = (LK > 0) ? LK : 1;
  localparam int CW = $clog2(K + 1);
  localparam int AW = DW + LK;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUM, S_LOAD} state_t;
  state_t state, state_nx;

  logic            vsync_d1;
  logic            vs_rise, vs_fall, pix_valid, ins_en, abort;
  logic [DW-1:0]   t_key [K];
  logic [3*DW-1:0] t_pix [K];
  logic [CW-1:0]   count;
  logic [DW-1:0]   kb [K];
  logic [3*DW-1:0] pb [K];
  logic            ins [K];
  logic [DW-1:0]   t_key_nx [K];
  logic [3*DW-1:0] t_pix_nx [K];
  logic [CW-1:0]   cnt_base, count_nx;
  logic [IW-1:0]   sum_idx;
  logic [AW-1:0]   acc_r, acc_g, acc_b;
  logic [DW-1:0]   new_r, new_g, new_b, ld_r, ld_g, ld_b;

  assign vs_rise   = bus.pre_frame_vsync & ~vsync_d1;
  assign vs_fall   = vsync_d1 & ~bus.pre_frame_vsync;
  assign pix_valid = bus.pre_frame_vsync & bus.pre_frame_href & bus.pre_frame_clken;
  assign ins_en    = pix_valid & ((state == S_COLLECT) | vs_rise);
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    abort    = 1'b0;
    case (state)
      S_IDLE:    if (vs_rise) state_nx = S_COLLECT;
      S_COLLECT: if (vs_fall) state_nx = S_SUM;
      S_SUM: begin
        if (vs_rise) begin
          state_nx = S_COLLECT;
          abort    = 1'b1;
        end else if (sum_idx == IW'(K - 1)) begin
          state_nx = S_LOAD;
        end
      end
      S_LOAD:    state_nx = vs_rise ? S_COLLECT : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // A vsync rise starts from an empty table, so a pixel on that same cycle is kept.
  always_comb begin
    cnt_base = vs_rise ? '0 : count;
    for (int i = 0; i < K; i++) begin
      kb[i]       = vs_rise ? '0 : t_key[i];
      pb[i]       = vs_rise ? '0 : t_pix[i];
      ins[i]      = (CW'(i) >= cnt_base) || (bus.pre_key > kb[i]);
      t_key_nx[i] = kb[i];
      t_pix_nx[i] = pb[i];
    end
    count_nx = cnt_base;
    if (ins_en) begin
      if (ins[0]) begin
        t_key_nx[0] = bus.pre_key;
        t_pix_nx[0] = bus.pre_img;
      end
      for (int i = 1; i < K; i++) begin
        if (ins[i] && ins[i-1]) begin
          t_key_nx[i] = kb[i-1];
          t_pix_nx[i] = pb[i-1];
        end else if (ins[i]) begin
          t_key_nx[i] = bus.pre_key;
          t_pix_nx[i] = bus.pre_img;
        end
      end
      if (cnt_base != CW'(K)) count_nx = cnt_base + 1'b1;
    end
  end

`ifdef ATMOS_LIGHT_SMOOTH_EN
  function automatic logic [DW-1:0] smooth(input logic [DW-1:0] prev, input logic [DW-1:0] nw);
    logic [DW+1:0] s;
    s = ({2'b00, prev} << 1) + {2'b00, prev} + {2'b00, nw};
    return DW'(s >> 2);
  endfunction
`endif

  always_comb begin
    if (count == CW'(K)) begin
      new_r = DW'(acc_r >> LK);
      new_g = DW'(acc_g >> LK);
      new_b = DW'(acc_b >> LK);
    end else begin
      new_r = t_pix[0][3*DW-1:2*DW];
      new_g = t_pix[0][2*DW-1:DW];
      new_b = t_pix[0][DW-1:0];
    end
`ifdef ATMOS_LIGHT_SMOOTH_EN
    ld_r = smooth(bus.post_a_r, new_r);
    ld_g = smooth(bus.post_a_g, new_g);
    ld_b = smooth(bus.post_a_b, new_b);
`else
    ld_r = new_r;
    ld_g = new_g;
    ld_b = new_b;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      // Held high so vsync already high at reset release is not mistaken for a rise.
      vsync_d1             <= 1'b1;
      bus.post_frame_vsync <= 1'b0;
      bus.post_frame_href  <= 1'b0;
      bus.post_frame_clken <= 1'b0;
      bus.post_a_r         <= DW'(A_INIT);
      bus.post_a_g         <= DW'(A_INIT);
      bus.post_a_b         <= DW'(A_INIT);
      bus.post_done        <= 1'b0;
      bus.post_overrun     <= 1'b0;
      count                <= '0;
      sum_idx              <= '0;
      acc_r                <= '0;
      acc_g                <= '0;
      acc_b                <= '0;
      for (int i = 0; i < K; i++) begin
        t_key[i] <= '0;
        t_pix[i] <= '0;
      end
    end else begin
      state                <= state_nx;
      vsync_d1             <= bus.pre_frame_vsync;
      bus.post_frame_vsync <= bus.pre_frame_vsync;
      bus.post_frame_href  <= bus.pre_frame_href;
      bus.post_frame_clken <= bus.pre_frame_clken;
      bus.post_done        <= 1'b0;
      bus.post_overrun     <= abort;
      count                <= count_nx;
      for (int i = 0; i < K; i++) begin
        t_key[i] <= t_key_nx[i];
        t_pix[i] <= t_pix_nx[i];
      end
      if (state == S_COLLECT && vs_fall) begin
        acc_r   <= '0;
        acc_g   <= '0;
        acc_b   <= '0;
        sum_idx <= '0;
      end else if (state == S_SUM && !vs_rise) begin
        acc_r <= acc_r + AW'(t_pix[sum_idx][3*DW-1:2*DW]);
        acc_g <= acc_g + AW'(t_pix[sum_idx][2*DW-1:DW]);
        acc_b <= acc_b + AW'(t_pix[sum_idx][DW-1:0]);
        if (sum_idx != IW'(K - 1)) sum_idx <= sum_idx + 1'b1;
      end
      if (state == S_LOAD) begin
        bus.post_done <= 1'b1;
        if (count != '0) begin
          bus.post_a_r <= ld_r;
          bus.post_a_g <= ld_g;
          bus.post_a_b <= ld_b;
        end
      end
    end
  end
endmodule

// File: tb/tb_atmos_light_topk.sv
// Directed bench for atmos_light_topk (DW=8, K=4, A_INIT=230); expected
// estimates are hand-computed and go through exp_q in load order.
module tb_atmos_light_topk;
  localparam int DW     = 8;
  localparam int K      = 4;
  localparam int A_INIT = 230;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  atmos_light_topk_if #(.DW(DW)) bus ();

  atmos_light_topk #(.DW(DW), .K(K), .A_INIT(A_INIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0]   cur_r, cur_g, cur_b;
  logic [3*DW-1:0] exp_q[$];
  logic [DW-1:0]   fk [32];
  logic [3*DW-1:0] fp [32];
  int              fn;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected held outputs after a load that produces (r,g,b) as the raw estimate.
  task automatic push_expected(input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b);
`ifdef ATMOS_LIGHT_SMOOTH_EN
    cur_r = DW'((3 * int'(cur_r) + int'(r)) / 4);
    cur_g = DW'((3 * int'(cur_g) + int'(g)) / 4);
    cur_b = DW'((3 * int'(cur_b) + int'(b)) / 4);
`else
    cur_r = r;
    cur_g = g;
    cur_b = b;
`endif
    exp_q.push_back({cur_r, cur_g, cur_b});
  endtask

  task automatic idle_inputs();
    bus.pre_frame_vsync = 1'b0;
    bus.pre_frame_href  = 1'b0;
    bus.pre_frame_clken = 1'b0;
    bus.pre_img         = '0;
    bus.pre_key         = '0;
  endtask

  // Drives vsync rise, fn pixels, one gap, then leaves vsync low for the fall edge.
  task automatic send_frame(input string name);
    bus.pre_frame_vsync = 1'b1;
    tick();
    total++;
    if ({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken} !== 3'b100) begin
      bad++;
      $display("FAIL %s sync_rise got=%b want=100", name,
               {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken});
    end
    for (int i = 0; i < fn; i++) begin
      bus.pre_frame_href  = 1'b1;
      bus.pre_frame_clken = 1'b1;
      bus.pre_key         = fk[i];
      bus.pre_img         = fp[i];
      tick();
      if (i == 0) begin
        total++;
        if ({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken} !== 3'b111) begin
          bad++;
          $display("FAIL %s sync_pixel got=%b want=111", name,
                   {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken});
        end
      end
    end
    bus.pre_frame_href  = 1'b0;
    bus.pre_frame_clken = 1'b0;
    tick();
    bus.pre_frame_vsync = 1'b0;
  endtask

  // Fall is sampled at the first edge (T); the load must appear at edge T+K+1 only.
  task automatic wait_load(input string name);
    int early;
    logic [3*DW-1:0] want;
    early = 0;
    for (int j = 0; j <= K; j++) begin
      tick();
      if (bus.post_done !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL %s early_done got=%0d want=0", name, early);
    end
    tick();
    total++;
    if (bus.post_done !== 1'b1) begin
      bad++;
      $display("FAIL %s done_pulse got=%b want=1", name, bus.post_done);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard got=empty want=entry", name);
    end else begin
      want = exp_q.pop_front();
      if ({bus.post_a_r, bus.post_a_g, bus.post_a_b} !== want) begin
        bad++;
        $display("FAIL %s estimate got=%0d/%0d/%0d want=%0d/%0d/%0d", name,
                 bus.post_a_r, bus.post_a_g, bus.post_a_b,
                 want[3*DW-1:2*DW], want[2*DW-1:DW], want[DW-1:0]);
      end
    end
    tick();
    total++;
    if (bus.post_done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_width got=%b want=0", name, bus.post_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pre_frame_vsync = 1'b1;
    bus.pre_frame_href  = 1'b1;
    bus.pre_frame_clken = 1'b1;
    bus.pre_img         = '1;
    bus.pre_key         = '1;
    repeat (3) tick();
    total++;
    if ({bus.post_a_r, bus.post_a_g, bus.post_a_b} !== {8'd230, 8'd230, 8'd230}) begin
      bad++;
      $display("FAIL reset_a got=%0d/%0d/%0d want=230/230/230", bus.post_a_r, bus.post_a_g, bus.post_a_b);
    end
    total++;
    if ({bus.post_done, bus.post_overrun} !== 2'b00) begin
      bad++;
      $display("FAIL reset_pulses got=%b want=00", {bus.post_done, bus.post_overrun});
    end
    total++;
    if ({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken} !== 3'b000) begin
      bad++;
      $display("FAIL reset_syncs got=%b want=000",
               {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken});
    end
    total++;
    if (dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got=%0d want=0", dbg_state);
    end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    cur_r = 8'd230;
    cur_g = 8'd230;
    cur_b = 8'd230;
    tick();
  endtask

  task automatic test_overrun();
    int dones;
    bus.pre_frame_vsync = 1'b1;
    tick();
    tick();
    bus.pre_frame_vsync = 1'b0;
    tick();
    tick();
    bus.pre_frame_vsync = 1'b1;
    tick();
    total++;
    if ({bus.post_overrun, bus.post_done} !== 2'b10) begin
      bad++;
      $display("FAIL overrun_pulse got=%b want=10", {bus.post_overrun, bus.post_done});
    end
    tick();
    total++;
    if (bus.post_overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_width got=%b want=0", bus.post_overrun);
    end
    total++;
    if (dbg_state !== 2'd1) begin
      bad++;
      $display("FAIL overrun_state got=%0d want=1", dbg_state);
    end
    dones = 0;
    for (int j = 0; j < K + 3; j++) begin
      tick();
      if (bus.post_done !== 1'b0) dones++;
    end
    total++;
    if (dones != 0 || {bus.post_a_r, bus.post_a_g, bus.post_a_b} !== {8'd230, 8'd230, 8'd230}) begin
      bad++;
      $display("FAIL overrun_hold got=%0d/%0d/%0d dones=%0d want=230/230/230 dones=0",
               bus.post_a_r, bus.post_a_g, bus.post_a_b, dones);
    end
    // Finishing the aborted frame with an empty table: pulse, values held.
    exp_q.push_back({cur_r, cur_g, cur_b});
    bus.pre_frame_vsync = 1'b0;
    wait_load("empty_frame");
  endtask

  task automatic test_top4_average();
    fn = 16;
    for (int i = 0; i < fn; i++) begin
      fk[i] = DW'(10 * (i + 1));
      fp[i] = {fk[i], fk[i] + 8'd1, fk[i] + 8'd2};
    end
    push_expected(8'd145, 8'd146, 8'd147);
    send_frame("top4_average");
    wait_load("top4_average");
  endtask

  task automatic test_ties();
    fn = 8;
    for (int i = 0; i < fn; i++) begin
      fk[i] = 8'd50;
      fp[i] = {DW'(i), DW'(i), DW'(i)};
    end
    push_expected(8'd1, 8'd1, 8'd1);
    send_frame("ties");
    wait_load("ties");
  endtask

  task automatic test_partial();
    fn = 2;
    fk[0] = 8'd20;
    fp[0] = {8'd10, 8'd20, 8'd30};
    fk[1] = 8'd90;
    fp[1] = {8'd200, 8'd100, 8'd50};
    push_expected(8'd200, 8'd100, 8'd50);
    send_frame("partial");
    wait_load("partial");
  endtask

  // Unordered keys: top four are 200,150,120,100 -> R 570>>2, G (255-key) 450>>2, B 4.
  task automatic test_mixed_order();
    logic [DW-1:0] keys [7];
    keys = '{8'd5, 8'd200, 8'd7, 8'd100, 8'd150, 8'd3, 8'd120};
    fn = 7;
    for (int i = 0; i < fn; i++) begin
      fk[i] = keys[i];
      fp[i] = {keys[i], 8'd255 - keys[i], 8'd4};
    end
    push_expected(8'd142, 8'd112, 8'd4);
    send_frame("mixed_order");
    wait_load("mixed_order");
  endtask

  task automatic test_reset_mid_sum();
    int dones;
    fn = 4;
    for (int i = 0; i < fn; i++) begin
      fk[i] = DW'(60 + i);
      fp[i] = {8'd9, 8'd9, 8'd9};
    end
    send_frame("reset_mid_sum");
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cur_r = 8'd230;
    cur_g = 8'd230;
    cur_b = 8'd230;
    dones = 0;
    for (int j = 0; j < K + 3; j++) begin
      tick();
      if (bus.post_done !== 1'b0) dones++;
    end
    total++;
    if (dones != 0 || {bus.post_a_r, bus.post_a_g, bus.post_a_b} !== {cur_r, cur_g, cur_b}) begin
      bad++;
      $display("FAIL reset_mid_sum got=%0d/%0d/%0d dones=%0d want=230/230/230 dones=0",
               bus.post_a_r, bus.post_a_g, bus.post_a_b, dones);
    end
  endtask

  initial begin
    idle_inputs();
    fn = 0;
    test_reset();
    test_overrun();
    test_top4_average();
    test_ties();
    test_partial();
    test_mixed_order();
    test_reset_mid_sum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/atmos_light_topk.md
ATMOS_LIGHT_TOPK -- requirements
Module: atmos_light_topk

Interface
REQ-001 Parameter DW, default 8, channel bit width.
REQ-002 Parameter K, default 8, number of brightest pixels averaged; power of two, 1..16.
REQ-003 Parameter A_INIT, default 230, per-channel output value after reset.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 pre_frame_vsync  input  1  frame valid, high during active frame.
REQ-007 pre_frame_href  input  1  line valid.
REQ-008 pre_frame_clken  input  1  pixel strobe.
REQ-009 pre_img  input  3*DW  pixel {R,G,B}, R in MSBs.
REQ-010 pre_key  input  DW  ranking key (dark-channel value) aligned with pre_img.
REQ-011 post_frame_vsync, post_frame_href, post_frame_clken  output  1 each  inputs delayed exactly 1 cycle.
REQ-012 post_a_r, post_a_g, post_a_b  output  DW each  atmospheric light estimate.
REQ-013 post_done  output  1  one-cycle pulse when a new estimate is loaded.
REQ-014 post_overrun  output  1  one-cycle pulse when an estimate is aborted.

Function
REQ-015 Valid pixel = href & clken & vsync; only valid pixels enter the table.
REQ-016 Table: K entries {key, R, G, B}, sorted descending by key, plus count 0..K.
REQ-017 Insertion: pixel inserted if count<K or key strictly greater than smallest stored key; lower entries shift down, smallest dropped; ties keep earlier pixel; one pixel per cycle sustained.
REQ-018 Table and count cleared on the cycle a vsync rising edge is detected (vsync & !vsync_d1).
REQ-019 FSM states IDLE, COLLECT, SUM, LOAD; IDLE->COLLECT on vsync rise; COLLECT->SUM on vsync fall (vsync_d1 & !vsync) at cycle T; SUM accumulates one entry per cycle over T+1..T+K; SUM->LOAD; LOAD->IDLE.
REQ-020 Accumulators per channel DW+log2(K) bits, no overflow; average = sum >> log2(K), truncating.
REQ-021 Outputs and post_done update at cycle T+K+1 (post_done high that cycle only).
REQ-022 count==K: output the average; 0<count<K: output entry 0 (brightest) unaveraged; count==0: outputs hold, post_done still pulses.
REQ-023 vsync rising during SUM: abort, outputs hold, no post_done, post_overrun pulses that cycle, FSM->COLLECT with table cleared.
REQ-024 Outputs hold between loads; sync delay path independent of FSM.

Reset
REQ-025 While rst_n low at a clock edge: post_a_* = A_INIT, post_done = 0, post_overrun = 0, post sync outputs = 0, table/count/accumulators = 0, FSM = IDLE.
REQ-026 Reset mid-frame or mid-SUM discards all partial state; next estimate requires a full vsync rise/fall.

Configuration
REQ-027 Macro ATMOS_LIGHT_SMOOTH_EN defined: each loaded channel = (3*previous + new) >> 2, computed at DW+2 bits; undefined: loaded value = new directly; latency unchanged either way.

Verification (DW=8, K=4, A_INIT=230)
REQ-028 Reset held 3 cycles -> post_a_* = 230/230/230, post_done = 0, syncs 0.
REQ-029 Frame of 16 pixels, keys 10..160 step 10, RGB = {key, key+1, key+2} -> at T+5 post_a = 145/146/147, post_done one cycle (macro off).
REQ-030 8 pixels all key 50, RGB = {i, i, i} for i = 0..7 -> output 1/1/1 (pixels 0..3 retained, sum 6 >> 2).
REQ-031 Frame with 2 valid pixels, keys 20 and 90, RGB 90-key pixel = {200,100,50} -> output 200/100/50.
REQ-032 vsync re-rises 2 cycles after fall -> post_overrun pulse, no post_done, outputs stay 230.
REQ-033 Macro on, REQ-029 stimulus from reset -> post_a = 208/209/209.
